// File: rtl/cksum_check.sv
// Receive-side one's-complement header checksum verifier.
// Sums one big-endian 16-bit word per clock, folds twice, reports pass/err.
module cksum_check #(
   parameter int HDR_MAX_LEN = 64,
   parameter int ADDR_W      = 8,
   parameter int ACC_W       = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic [HDR_MAX_LEN*8-1:0] pkt_hdr_i,
   input  logic [ADDR_W-1:0]        field_start_i,
   input  logic [ADDR_W-1:0]        field_len_i,
   output logic                     check_ready_o,
   output logic                     check_pass_o,
   output logic                     check_err_o,
   output logic [15:0]              sum_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SUM   = 3'd1;
   localparam logic [2:0] S_FOLD1 = 3'd2;
   localparam logic [2:0] S_FOLD2 = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] TWO   = (ADDR_W+1)'(2);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(HDR_MAX_LEN);

   logic [2:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ADDR_W:0]  addr_q, addr_d;
   logic [ADDR_W:0]  end_q, end_d;
   logic             ready_q, ready_d;
   logic             pass_q, pass_d;
   logic             err_q, err_d;
   logic [15:0]      sum_q, sum_d;

   logic [ADDR_W:0]  end_w;
   logic             range_bad;
   logic [ADDR_W:0]  addr_p1;
   logic [ADDR_W:0]  addr_p2;
   logic [7:0]       hi_b;
   logic [7:0]       lo_b;
   logic [15:0]      fold_s;

   assign end_w     = {1'b0, field_start_i} + {1'b0, field_len_i};
   assign range_bad = (field_len_i == '0) || (end_w > LIMIT);
   assign addr_p1   = addr_q + ONE;
   assign addr_p2   = addr_q + TWO;
   assign fold_s    = acc_q[15:0] + {15'd0, acc_q[16]};

   // Low byte of an odd-length tail is zero-padded; hdr[end] is never selected.
   always_comb begin
      hi_b = 8'h00;
      lo_b = 8'h00;
      for (int i = 0; i < HDR_MAX_LEN; i++) begin
         if ((ADDR_W+1)'(i) == addr_q)
            hi_b = pkt_hdr_i[8*i +: 8];
         if (((ADDR_W+1)'(i) == addr_p1) && (addr_p1 < end_q))
            lo_b = pkt_hdr_i[8*i +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      addr_d  = addr_q;
      end_d   = end_q;
      ready_d = ready_q;
      pass_d  = pass_q;
      err_d   = err_q;
      sum_d   = sum_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               addr_d = {1'b0, field_start_i};
               end_d  = end_w;
               acc_d  = '0;
               if (range_bad) begin
                  err_d   = 1'b1;
                  pass_d  = 1'b0;
                  sum_d   = 16'h0000;
                  ready_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_SUM;
               end
            end
         end
         S_SUM: begin
            acc_d  = acc_q + ACC_W'({hi_b, lo_b});
            addr_d = addr_p2;
            if (addr_p2 >= end_q)
               state_d = S_FOLD1;
         end
         S_FOLD1: begin
            acc_d   = ACC_W'(acc_q[ACC_W-1:16]) + ACC_W'(acc_q[15:0]);
            state_d = S_FOLD2;
         end
         S_FOLD2: begin
            sum_d   = fold_s;
            pass_d  = (fold_s == 16'hFFFF);
            err_d   = 1'b0;
            ready_d = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!start_i) begin
               ready_d = 1'b0;
               pass_d  = 1'b0;
               err_d   = 1'b0;
               sum_d   = 16'h0000;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         addr_q  <= '0;
         end_q   <= '0;
         ready_q <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 1'b0;
         sum_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         addr_q  <= addr_d;
         end_q   <= end_d;
         ready_q <= ready_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         sum_q   <= sum_d;
      end
   end

   assign check_ready_o = ready_q;
   assign check_pass_o  = pass_q;
   assign check_err_o   = err_q;
   assign sum_o         = sum_q;

endmodule
